ifu_prefetch: RTL

- Parametrised instruction-fetch unit that replaces the single-instruction, blocking PC/fetch block.
- Issues sequential fetch requests to an instruction-memory port with a valid/ready handshake and tolerates arbitrary in-order response latency.
- Buffers fetched instructions in a prefetch FIFO and hands them to decode with a valid/ready handshake.
- Supports redirects (branch/jump) with flush of buffered and in-flight fetches, and halts on ebreak with a one-cycle trap pulse.

---
 rtl/ifu_prefetch.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit with a prefetch FIFO.
// Issues sequential fetches to an in-order instruction memory. Requests are
// credit-limited so that the in-flight count plus the buffered count never
// exceeds DEPTH. Redirects flush the FIFO and discard in-flight responses.
// An ebreak reaching decode halts the unit and pulses trap for one cycle.
module ifu_prefetch #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [31:0]     EBREAK_OP = 32'h0010_0073
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_pc,
    output logic [31:0]     inst_data,
    output logic            trap,
    output logic            halted
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            halted_q, halted_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [31:0]     data_mem_q [DEPTH];

    logic            redirect_s;
    logic            credit_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            inst_valid_s;
    logic            pop_s;
    logic            drop_s;
    logic            push_s;

    // Handshake and control decode: credit check, fire, pop, drop and push qualifiers.
    always_comb begin
        redirect_s   = redirect_valid & ~halted_q;
        credit_s     = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW + 1)'(DEPTH);
        // rst_n gates the request so nothing is offered while reset is held.
        req_valid_s  = rst_n & ~halted_q & ~redirect_valid & credit_s;
        req_fire_s   = req_valid_s & imem_req_ready;
        inst_valid_s = (count_q != CW'(0)) & ~halted_q;
        pop_s        = inst_valid_s & inst_ready;
        drop_s       = imem_resp_valid & (drop_cnt_q != CW'(0));
        push_s       = imem_resp_valid & ~drop_s & ~halted_q & ~redirect_s;
    end

    // Next-state logic for fetch/response PCs, credit counters and halt/trap.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire_s) - CW'(imem_resp_valid);
        drop_cnt_d    = drop_cnt_q;
        trap_d        = pop_s & (inst_data == EBREAK_OP);
        halted_d      = halted_q | trap_d;

        if (redirect_s) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            // drop_cnt is always a subset of outstanding, so after a redirect
            // every in-flight request not answered this cycle must be dropped.
            drop_cnt_d = outstanding_q - CW'(imem_resp_valid);
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (push_s) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
            end else begin
                resp_pc_d = resp_pc_q;
            end
            if (drop_s) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // Next-state logic for FIFO occupancy and pointers; redirect empties the FIFO.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_s) begin
            count_d  = CW'(0);
            rd_ptr_d = AW'(0);
            wr_ptr_d = AW'(0);
        end else begin
            count_d  = count_q + CW'(push_s) - CW'(pop_s);
            rd_ptr_d = rd_ptr_q + AW'(pop_s);
            wr_ptr_d = wr_ptr_q + AW'(push_s);
        end
    end

    // State registers for PCs, counters, pointers and halt/trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_VEC;
            resp_pc_q     <= RESET_VEC;
            outstanding_q <= CW'(0);
            drop_cnt_q    <= CW'(0);
            count_q       <= CW'(0);
            rd_ptr_q      <= AW'(0);
            wr_ptr_q      <= AW'(0);
            halted_q      <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            halted_q      <= halted_d;
            trap_q        <= trap_d;
        end
    end

    // FIFO storage: write the accepted response with its PC at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
            data_mem_q[wr_ptr_q] <= imem_resp_data;
        end else begin
            pc_mem_q[wr_ptr_q]   <= pc_mem_q[wr_ptr_q];
            data_mem_q[wr_ptr_q] <= data_mem_q[wr_ptr_q];
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = inst_valid_s;
    assign inst_pc        = pc_mem_q[rd_ptr_q];
    assign inst_data      = data_mem_q[rd_ptr_q];
    assign trap           = trap_q;
    assign halted         = halted_q;

endmodule
